// File: rtl/mem_port_arb_pkg.sv
// Shared types for the IF/MA memory port arbiter: state encoding, requester IDs, width defaults.
package mem_port_arb_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 24;
  localparam int unsigned DATA_WIDTH_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_MA = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_MA = 1'b1
  } req_id_e;

  // A limit of 0 disables the guard entirely (pure MA priority).
  function automatic logic starve_hit(input int unsigned cnt, input int unsigned lim);
    return (lim != 0) && (cnt == lim);
  endfunction

endpackage

// File: rtl/mem_port_wdog.sv
// Wait-state watchdog for the memory port arbiter; only built when DIAD_MEMARB_TIMEOUT_EN is defined.
`ifdef DIAD_MEMARB_TIMEOUT_EN
module mem_port_wdog #(
  parameter int unsigned CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic clear_i,
  output logic expire_o
);
  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // Loaded with CYCLES-1 so expire lands on the CYCLES-th busy cycle.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (start_i) begin
      cnt_d   = CW'(CYCLES - 1);
      armed_d = 1'b1;
    end else if (clear_i) begin
      armed_d = 1'b0;
    end else if (armed_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expire_o = armed_q && (cnt_q == '0);

endmodule
`endif

// File: rtl/mem_port_arb.sv
// Shared memory port arbiter between IF and MA: MA priority, IF starvation guard, registered handshakes.
// Define DIAD_MEMARB_TIMEOUT_EN to abort transactions that wait too long for iw_mem_ready.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_if_req,
  input  logic [ADDR_WIDTH-1:0] iw_if_addr,
  output logic                  ow_if_gnt,
  output logic                  ow_if_rvalid,
  output logic [DATA_WIDTH-1:0] ow_if_rdata,
  output logic                  ow_stall_if,
  input  logic                  iw_ma_req,
  input  logic                  iw_ma_we,
  input  logic [ADDR_WIDTH-1:0] iw_ma_addr,
  input  logic [DATA_WIDTH-1:0] iw_ma_wdata,
  output logic                  ow_ma_gnt,
  output logic                  ow_ma_rvalid,
  output logic [DATA_WIDTH-1:0] ow_ma_rdata,
  output logic                  ow_stall_ma,
  output logic                  ow_mem_en,
  output logic                  ow_mem_we,
  output logic [ADDR_WIDTH-1:0] ow_mem_addr,
  output logic [DATA_WIDTH-1:0] ow_mem_wdata,
  input  logic [DATA_WIDTH-1:0] iw_mem_rdata,
  input  logic                  iw_mem_ready,
  output logic                  ow_err
);
  localparam int unsigned   SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e            state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  if_gnt_q, if_gnt_d, ma_gnt_q, ma_gnt_d;
  logic                  if_rvalid_q, if_rvalid_d, ma_rvalid_q, ma_rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, ma_rdata_q, ma_rdata_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic                  eff_if, eff_ma, if_wins, wd_expire, done;

  // A requester completing this cycle must not be re-granted on its stale request.
  assign eff_if  = iw_if_req & ~if_rvalid_q;
  assign eff_ma  = iw_ma_req & ~ma_rvalid_q;
  assign if_wins = eff_if & (~eff_ma | starve_hit(32'(starve_q), STARVE_MAX));
  assign done    = iw_mem_ready | wd_expire;

`ifdef DIAD_MEMARB_TIMEOUT_EN
  mem_port_wdog #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (iw_clk),
    .rst_ni   (iw_rst),
    .start_i  (if_gnt_d | ma_gnt_d),
    .clear_i  (if_rvalid_d | ma_rvalid_d),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    ma_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ma_rvalid_d = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    ma_rdata_d  = ma_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_wins) begin
          state_d     = ST_BUSY_IF;
          if_gnt_d    = 1'b1;
          starve_d    = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = iw_if_addr;
          mem_wdata_d = '0;
        end else if (eff_ma) begin
          state_d     = ST_BUSY_MA;
          ma_gnt_d    = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = iw_ma_we;
          mem_addr_d  = iw_ma_addr;
          mem_wdata_d = iw_ma_wdata;
          if (!iw_if_req)                starve_d = '0;
          else if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
        end
      end
      ST_BUSY_IF: begin
        if (done) begin
          state_d     = ST_IDLE;
          if_rvalid_d = 1'b1;
          err_d       = ~iw_mem_ready;
          if_rdata_d  = iw_mem_ready ? iw_mem_rdata : '0;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
        end
      end
      ST_BUSY_MA: begin
        if (done) begin
          state_d     = ST_IDLE;
          ma_rvalid_d = 1'b1;
          err_d       = ~iw_mem_ready;
          ma_rdata_d  = (iw_mem_ready & ~mem_we_q) ? iw_mem_rdata : '0;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      ma_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ma_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      ma_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      ma_gnt_q    <= ma_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ma_rvalid_q <= ma_rvalid_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      ma_rdata_q  <= ma_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ow_if_gnt    = if_gnt_q;
  assign ow_if_rvalid = if_rvalid_q;
  assign ow_if_rdata  = if_rdata_q;
  assign ow_stall_if  = iw_if_req & ~if_rvalid_q;
  assign ow_ma_gnt    = ma_gnt_q;
  assign ow_ma_rvalid = ma_rvalid_q;
  assign ow_ma_rdata  = ma_rdata_q;
  assign ow_stall_ma  = iw_ma_req & ~ma_rvalid_q;
  assign ow_mem_en    = mem_en_q;
  assign ow_mem_we    = mem_we_q;
  assign ow_mem_addr  = mem_addr_q;
  assign ow_mem_wdata = mem_wdata_q;
  assign ow_err       = err_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: transaction-level reference model checked every cycle plus directed scenarios.
// Define DIAD_MEMARB_TIMEOUT_EN to also exercise the timeout abort.
module tb_mem_port_arb;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 64;
`ifdef DIAD_MEMARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, ma_req = 1'b0, ma_we = 1'b0, mem_ready = 1'b0;
  logic [23:0] if_addr = '0, ma_addr = '0, ma_wdata = '0, mem_rdata = '0;
  logic        ow_if_gnt, ow_if_rvalid, ow_stall_if, ow_ma_gnt, ow_ma_rvalid, ow_stall_ma;
  logic        ow_mem_en, ow_mem_we, ow_err;
  logic [23:0] ow_if_rdata, ow_ma_rdata, ow_mem_addr, ow_mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;
  int wait_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arb #(
    .ADDR_WIDTH(24), .DATA_WIDTH(24), .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_if_req(if_req), .iw_if_addr(if_addr),
    .ow_if_gnt(ow_if_gnt), .ow_if_rvalid(ow_if_rvalid), .ow_if_rdata(ow_if_rdata), .ow_stall_if(ow_stall_if),
    .iw_ma_req(ma_req), .iw_ma_we(ma_we), .iw_ma_addr(ma_addr), .iw_ma_wdata(ma_wdata),
    .ow_ma_gnt(ow_ma_gnt), .ow_ma_rvalid(ow_ma_rvalid), .ow_ma_rdata(ow_ma_rdata), .ow_stall_ma(ow_stall_ma),
    .ow_mem_en(ow_mem_en), .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
    .iw_mem_rdata(mem_rdata), .iw_mem_ready(mem_ready), .ow_err(ow_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Memory responder: completes after wait_n wait states, data derived from the address.
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (ow_mem_en === 1'b1) begin
        mem_ready = (bcnt == wait_n);
        mem_rdata = ow_mem_addr ^ 24'hC3A5F0;
        bcnt++;
      end else begin
        mem_ready = 1'b0;
        bcnt = 0;
      end
    end
  end

  // Reference model: one owner of the port at a time, outputs as registered transaction events.
  int          m_owner, m_starve, m_wait;
  bit          m_if_gnt, m_ma_gnt, m_if_rv, m_ma_rv, m_err, m_en, m_we;
  logic [23:0] m_addr, m_wdata, m_if_rd, m_ma_rd;

  always @(posedge clk) begin
    bit          want_if, want_ma, if_first, to;
    logic [23:0] d;
    want_if = if_req && !m_if_rv;
    want_ma = ma_req && !m_ma_rv;
    m_if_gnt = 0; m_ma_gnt = 0; m_if_rv = 0; m_ma_rv = 0; m_err = 0;
    if (!rst) begin
      m_owner = 0; m_starve = 0; m_wait = 0; m_en = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_if_rd = 0; m_ma_rd = 0;
    end else if (m_owner == 0) begin
      if_first = want_if && (!want_ma || (STARVE_MAX > 0 && m_starve >= STARVE_MAX));
      if (if_first) begin
        m_owner = 1; m_if_gnt = 1; m_starve = 0; m_wait = 0;
        m_en = 1; m_we = 0; m_addr = if_addr; m_wdata = 0;
      end else if (want_ma) begin
        m_owner = 2; m_ma_gnt = 1; m_wait = 0;
        m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
        m_en = 1; m_we = ma_we; m_addr = ma_addr; m_wdata = ma_wdata;
      end
    end else begin
      m_wait++;
      if (mem_ready || (TO_EN && m_wait >= TIMEOUT)) begin
        to = !mem_ready;
        d  = (to || (m_owner == 2 && m_we)) ? 24'h0 : mem_rdata;
        if (m_owner == 1) begin m_if_rv = 1; m_if_rd = d; end
        else              begin m_ma_rv = 1; m_ma_rd = d; end
        m_err = to; m_owner = 0; m_en = 0; m_we = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("if_gnt",    32'(ow_if_gnt),    32'(m_if_gnt));
      chk("ma_gnt",    32'(ow_ma_gnt),    32'(m_ma_gnt));
      chk("if_rvalid", 32'(ow_if_rvalid), 32'(m_if_rv));
      chk("ma_rvalid", 32'(ow_ma_rvalid), 32'(m_ma_rv));
      chk("if_rdata",  32'(ow_if_rdata),  32'(m_if_rd));
      chk("ma_rdata",  32'(ow_ma_rdata),  32'(m_ma_rd));
      chk("mem_en",    32'(ow_mem_en),    32'(m_en));
      chk("err",       32'(ow_err),       32'(m_err));
      chk("stall_if",  32'(ow_stall_if),  32'(if_req & ~m_if_rv));
      chk("stall_ma",  32'(ow_stall_ma),  32'(ma_req & ~m_ma_rv));
      if (m_en) begin
        chk("mem_we",    32'(ow_mem_we),    32'(m_we));
        chk("mem_addr",  32'(ow_mem_addr),  32'(m_addr));
        chk("mem_wdata", 32'(ow_mem_wdata), 32'(m_wdata));
      end
    end
  end

  // Event log used by the directed scenarios.
  int if_gnt_cyc, ma_gnt_cyc, if_rv_cyc, ma_rv_cyc, n_if_gnt, n_ma_gnt, n_ma_rv, en_cnt;
  initial forever begin
    @(negedge clk);
    if (ow_if_gnt === 1'b1)    begin if_gnt_cyc = cyc; n_if_gnt++; end
    if (ow_ma_gnt === 1'b1)    begin ma_gnt_cyc = cyc; n_ma_gnt++; end
    if (ow_if_rvalid === 1'b1) if_rv_cyc = cyc;
    if (ow_ma_rvalid === 1'b1) begin ma_rv_cyc = cyc; n_ma_rv++; end
    if (ow_mem_en === 1'b1)    en_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rv(input bit ma, input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = ma ? (ow_ma_rvalid === 1'b1) : (ow_if_rvalid === 1'b1);
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n, k0, k1, r0;
    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_if_gnt",   32'(ow_if_gnt),    32'd0);
    chk("rst_ma_gnt",   32'(ow_ma_gnt),    32'd0);
    chk("rst_if_rv",    32'(ow_if_rvalid), 32'd0);
    chk("rst_ma_rv",    32'(ow_ma_rvalid), 32'd0);
    chk("rst_mem_en",   32'(ow_mem_en),    32'd0);
    chk("rst_if_rdata", 32'(ow_if_rdata),  32'd0);
    chk("rst_ma_rdata", 32'(ow_ma_rdata),  32'd0);
    chk("rst_err",      32'(ow_err),       32'd0);

    // IF read, zero wait states.
    wait_n = 0;
    tick(); n = cyc; if_req = 1; if_addr = 24'h000010;
    @(negedge clk);
    chk("t1_stall_at_req", 32'(ow_stall_if), 32'd1);
    wait_rv(0, "t1_if_rvalid_seen");
    chk("t1_stall_at_rv", 32'(ow_stall_if), 32'd0);
    tick(); if_req = 0;
    chk("t1_gnt_cycle",   32'(if_gnt_cyc),  32'(n + 1));
    chk("t1_rv_cycle",    32'(if_rv_cyc),   32'(n + 2));
    chk("t1_rdata",       32'(ow_if_rdata), 32'hC3A5E0);

    // Simultaneous IF and MA reads: MA first, IF after the bubble.
    tick(); n = cyc; if_req = 1; if_addr = 24'h000040; ma_req = 1; ma_we = 0; ma_addr = 24'h000030;
    wait_rv(1, "t2_ma_rvalid_seen");
    tick(); ma_req = 0;
    wait_rv(0, "t2_if_rvalid_seen");
    tick(); if_req = 0;
    chk("t2_ma_gnt_cycle", 32'(ma_gnt_cyc),  32'(n + 1));
    chk("t2_if_gnt_cycle", 32'(if_gnt_cyc),  32'(n + 3));
    chk("t2_if_rv_cycle",  32'(if_rv_cyc),   32'(n + 4));
    chk("t2_ma_rdata",     32'(ow_ma_rdata), 32'hC3A5C0);
    chk("t2_if_rdata",     32'(ow_if_rdata), 32'hC3A5B0);

    // MA write with 3 wait states.
    wait_n = 3;
    tick(); en_cnt = 0; r0 = n_ma_rv;
    ma_req = 1; ma_we = 1; ma_addr = 24'h000020; ma_wdata = 24'h123456;
    @(negedge clk);
    @(negedge clk);
    chk("t3_mem_we",    32'(ow_mem_we),    32'd1);
    chk("t3_mem_addr",  32'(ow_mem_addr),  32'h000020);
    chk("t3_mem_wdata", 32'(ow_mem_wdata), 32'h123456);
    wait_rv(1, "t3_ma_rvalid_seen");
    tick(); ma_req = 0; ma_we = 0;
    repeat (3) tick();
    chk("t3_en_cycles",  32'(en_cnt),        32'd4);
    chk("t3_rv_pulses",  32'(n_ma_rv - r0),  32'd1);
    chk("t3_ma_rdata",   32'(ow_ma_rdata),   32'd0);

    // Starvation guard: four MA wins while IF is waiting, then IF is forced through.
    wait_n = 0;
    k0 = n_ma_gnt; k1 = n_if_gnt;
    for (int ep = 0; ep < 4; ep++) begin
      tick(); if_req = 1; if_addr = 24'h000200; ma_req = 1; ma_we = 0; ma_addr = 24'h000100 + 24'(ep);
      tick(); if_req = 0;
      wait_rv(1, "t4_ma_rvalid_seen");
      tick(); ma_req = 0;
    end
    chk("t4_ma_grants", 32'(n_ma_gnt - k0), 32'd4);
    chk("t4_if_grants", 32'(n_if_gnt - k1), 32'd0);
    tick(); n = cyc; if_req = 1; ma_req = 1; ma_addr = 24'h0001F0;
    wait_rv(0, "t4_if_rvalid_seen");
    tick(); if_req = 0;
    wait_rv(1, "t4_ma_resume_seen");
    tick(); ma_req = 0;
    chk("t4_if_forced_cycle", 32'(if_gnt_cyc), 32'(n + 1));
    chk("t4_ma_resume_cycle", 32'(ma_gnt_cyc), 32'(n + 3));

    // Reset while MA is waiting on memory.
    wait_n = 100000;
    tick(); ma_req = 1; ma_we = 0; ma_addr = 24'h000050;
    tick();
    tick(); rst = 0; ma_req = 0;
    tick(); rst = 1; r0 = n_ma_rv;
    @(negedge clk);
    chk("t5_mem_en",   32'(ow_mem_en),    32'd0);
    chk("t5_ma_rv",    32'(ow_ma_rvalid), 32'd0);
    chk("t5_ma_rdata", 32'(ow_ma_rdata),  32'd0);
    chk("t5_if_rdata", 32'(ow_if_rdata),  32'd0);
    repeat (4) tick();
    chk("t5_no_rvalid", 32'(n_ma_rv - r0), 32'd0);
    wait_n = 0;
    tick(); ma_req = 1; ma_addr = 24'h000060;
    wait_rv(1, "t5_after_reset_seen");
    chk("t5_after_reset_rdata", 32'(ow_ma_rdata), 32'hC3A590);
    tick(); ma_req = 0;

`ifdef DIAD_MEMARB_TIMEOUT_EN
    wait_n = 100000;
    tick(); ma_req = 1; ma_we = 0; ma_addr = 24'h000070;
    wait_rv(1, "t6_abort_seen");
    chk("t6_err_with_rv", 32'(ow_err), 32'd1);
    tick(); ma_req = 0; wait_n = 0;
    chk("t6_busy_cycles", 32'(ma_rv_cyc - ma_gnt_cyc), 32'd64);
    chk("t6_ma_rdata",    32'(ow_ma_rdata),            32'd0);
    chk("t6_idle_mem_en", 32'(ow_mem_en),              32'd0);
`endif

    repeat (5) tick();
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
Arbitrates the single shared memory port between the instruction-fetch stage (IF) and the memory-access stage (MA) of the diad pipeline. It sequences each transaction through a small FSM, absorbs memory wait states, returns read data and completion pulses, and drives per-stage stall lines. MA has priority, with a starvation guard so IF cannot be blocked indefinitely.

Parameters:
ADDR_WIDTH, 24, width of memory address.
DATA_WIDTH, 24, width of memory data word.
STARVE_MAX, 4, consecutive MA grants allowed while IF waits before IF is forced through; 0 = pure MA priority.
TIMEOUT_CYCLES, 64, wait-state limit per transaction (used only with the optional feature).

Ports:
iw_clk  in  1  clock, all logic on rising edge
iw_rst  in  1  synchronous reset, active-low (0 = reset)
iw_if_req  in  1  IF read request; held until ow_if_rvalid
iw_if_addr  in  ADDR_WIDTH  IF read address
ow_if_gnt  out  1  1-cycle pulse: IF transaction started
ow_if_rvalid  out  1  1-cycle pulse: IF read complete
ow_if_rdata  out  DATA_WIDTH  IF read data, valid with ow_if_rvalid
ow_stall_if  out  1  stall IF stage
iw_ma_req  in  1  MA request; held until ow_ma_rvalid
iw_ma_we  in  1  1 = write, 0 = read
iw_ma_addr  in  ADDR_WIDTH  MA address
iw_ma_wdata  in  DATA_WIDTH  MA write data
ow_ma_gnt  out  1  1-cycle pulse: MA transaction started
ow_ma_rvalid  out  1  1-cycle pulse: MA read/write complete
ow_ma_rdata  out  DATA_WIDTH  MA read data; 0 on write completion
ow_stall_ma  out  1  stall MA stage
ow_mem_en  out  1  memory access active
ow_mem_we  out  1  memory write
ow_mem_addr  out  ADDR_WIDTH  memory address
ow_mem_wdata  out  DATA_WIDTH  memory write data
iw_mem_rdata  in  DATA_WIDTH  memory read data, valid when iw_mem_ready
iw_mem_ready  in  1  memory completes current access this cycle
ow_err  out  1  1-cycle pulse with rvalid on timeout abort; constant 0 without the optional feature

Behaviour:
- Reset (iw_rst=0 at edge): state IDLE; all outputs 0; starvation counter 0; any in-flight transaction dropped, no rvalid issued.
- FSM states: IDLE, BUSY_IF, BUSY_MA.
- IDLE: effective requests are iw_x_req masked by ow_x_rvalid in the same cycle, preventing re-grant of a completing requester. If any effective request is present, the next edge enters BUSY_x. ow_x_gnt=1 and ow_mem_* are loaded from the winner's inputs, all registered.
- Arbitration: MA wins unless IF is requesting and starve count == STARVE_MAX (STARVE_MAX>0). Counter increments on each MA grant while iw_if_req=1, saturates at STARVE_MAX, and clears on IF grant or when iw_if_req=0 at an MA grant.
- BUSY_x: ow_mem_en=1; address/data/we held stable. An edge with iw_mem_ready=1 returns to IDLE, pulses ow_x_rvalid next cycle, captures iw_mem_rdata into ow_x_rdata (MA write: 0), and deasserts ow_mem_en.
- Minimum latency: request at cycle N -> gnt and mem_en at N+1 -> ready at N+1 -> rvalid at N+2. Back-to-back transactions have a 1-cycle IDLE bubble.
- Stalls, combinational: ow_stall_x = iw_x_req & ~ow_x_rvalid.
- ow_x_rdata holds its value until the next rvalid for that requester.
- Requests dropped before grant are ignored. Dropping after grant is illegal; the transaction still completes.

Optional Feature:
DIAD_MEMARB_TIMEOUT_EN. With the macro defined, a counter runs in BUSY_x. After TIMEOUT_CYCLES cycles without iw_mem_ready, the FSM aborts to IDLE and pulses ow_x_rvalid with ow_err=1 and rdata=0. Without the macro, BUSY waits indefinitely and ow_err is tied 0.

Decomposition:
- Shared include src2/memarb.vh: FSM state encodings (IDLE=2'd0, BUSY_IF=2'd1, BUSY_MA=2'd2) and the requester-ID constants.
- Width defaults are taken from src2/sizes.vh.
- One natural sub-module, mem_port_wdog: timeout counter with start/clear/expire, instantiated only under the macro.

Test Plan:
- IF read to 0x000010, iw_mem_ready=1 immediately -> if_gnt at N+1, if_rvalid at N+2 with the rdata the memory returned; stall_if high N..N+1.
- IF and MA read requested in the same cycle -> MA granted first; IF granted after MA rvalid plus a 1-cycle bubble.
- MA write 0x123456 to 0x000020 with 3 wait states -> mem_en/we/addr/wdata stable 4 cycles; ma_rvalid once; ma_rdata=0.
- MA held continuously with IF pending, STARVE_MAX=4 -> exactly 4 MA grants, then 1 IF grant, then MA resumes.
- Reset asserted during BUSY_MA -> next cycle IDLE, all outputs 0, no rvalid; new request afterward is served normally.
- (Macro on) iw_mem_ready held 0 -> after 64 busy cycles, rvalid and ow_err pulse together; FSM returns to IDLE.
